// File: rtl/fourstate_bus_sampler_if.sv
// Bus-side signal bundle of the 4-state bus sampler. The sampled bus, the
// capture strobe and the head-record handshake travel together. The master
// modport is the stimulus/consumer side and the slave modport is the sampler.
interface fourstate_bus_sampler_if #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(WIDTH + 1),
    parameter int AW    = $clog2(DEPTH + 1)
);
    logic [WIDTH-1:0]   bus_in;
    logic               sample_i;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] out_code;
    logic [CW-1:0]      out_x_cnt;
    logic [CW-1:0]      out_z_cnt;
    logic               out_all_z;
    logic [AW-1:0]      fifo_count;
    logic               overflow;
    logic [7:0]         drop_cnt;

    modport master (
        output bus_in, sample_i, out_ready,
        input  out_valid, out_code, out_x_cnt, out_z_cnt, out_all_z,
               fifo_count, overflow, drop_cnt
    );

    modport slave (
        input  bus_in, sample_i, out_ready,
        output out_valid, out_code, out_x_cnt, out_z_cnt, out_all_z,
               fifo_count, overflow, drop_cnt
    );
endinterface

// File: rtl/fourstate_bus_sampler.sv
// Sampling monitor for multi-driven 4-state nets. Each strobe classifies
// every bus bit as 0/1/z/x, counts the x and z bits and queues the record in
// a small FIFO that a consumer drains over valid/ready. The head record is
// read straight out of the storage registers at the read pointer, so a record
// written on one edge is visible right after it, and a pop exposes the next
// entry with no bubble. Outputs are forced to zero while the FIFO is empty, so
// nothing unknown ever leaves the block.
module fourstate_bus_sampler #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(WIDTH + 1),
    parameter int AW    = $clog2(DEPTH + 1)
) (
    input logic                   clk,
    input logic                   rst,
    fourstate_bus_sampler_if.slave bus
);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [2*WIDTH-1:0] code;
        logic [CW-1:0]      x_cnt;
        logic [CW-1:0]      z_cnt;
        logic               all_z;
    } rec_t;

    // Case-equality classification: 0->00, 1->01, z->10, anything else (x)->11.
    function automatic rec_t encode(input logic [WIDTH-1:0] b);
        rec_t r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (b[i] === 1'b0) begin
                r.code[2*i +: 2] = 2'b00;
            end else if (b[i] === 1'b1) begin
                r.code[2*i +: 2] = 2'b01;
            end else if (b[i] === 1'bz) begin
                r.code[2*i +: 2] = 2'b10;
                r.z_cnt = r.z_cnt + CW'(1);
            end else begin
                r.code[2*i +: 2] = 2'b11;
                r.x_cnt = r.x_cnt + CW'(1);
            end
        end
        r.all_z = (r.z_cnt == CW'(WIDTH));
        return r;
    endfunction

    // Drop counter sticks at its ceiling instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    rec_t          mem [DEPTH];
    rec_t          sample_rec;
    rec_t          head;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [AW-1:0] count;
    logic          ovf;
    logic [7:0]    drops;
    logic          full;
    logic          valid;
    logic          pop;
    logic          accept;
    logic          drop;

    // Handshake decode; a pop while full frees the slot a same-cycle push uses.
    always_comb begin
        full       = (count == AW'(DEPTH));
        valid      = (count != '0);
        pop        = valid & bus.out_ready;
        accept     = bus.sample_i & (~full | pop);
        drop       = bus.sample_i & full & ~pop;
        sample_rec = encode(bus.bus_in);
    end

    // Pointers, occupancy and the sticky overflow/drop bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            drops  <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + PW'(1);
            if (pop)    rd_ptr <= rd_ptr + PW'(1);
            count <= count + AW'(accept) - AW'(pop);
            if (drop) begin
                ovf   <= 1'b1;
                drops <= sat_inc8(drops);
            end
        end
    end

    // Record storage; contents are only ever read at occupied slots.
    always_ff @(posedge clk) begin
        if (!rst && accept) mem[wr_ptr] <= sample_rec;
    end

    // Head record presentation, gated to zero when nothing is queued.
    always_comb begin
        head = '0;
        if (valid) head = mem[rd_ptr];
    end

    assign bus.out_valid  = valid;
    assign bus.out_code   = head.code;
    assign bus.out_x_cnt  = head.x_cnt;
    assign bus.out_z_cnt  = head.z_cnt;
    assign bus.out_all_z  = head.all_z;
    assign bus.fifo_count = count;
    assign bus.overflow   = ovf;
    assign bus.drop_cnt   = drops;
endmodule

// File: tb/tb_fourstate_bus_sampler.sv
// Bench for the 4-state bus sampler: a 24-bit instance checked against a
// queue-based reference model, plus a 4-bit instance for the small encoding case.
module tb_fourstate_bus_sampler;
    localparam int W  = 24;
    localparam int D  = 4;
    localparam int CW = $clog2(W + 1);
    localparam int AW = $clog2(D + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fourstate_bus_sampler_if #(.WIDTH(W), .DEPTH(D)) bif ();
    fourstate_bus_sampler #(.WIDTH(W), .DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bif));

    fourstate_bus_sampler_if #(.WIDTH(4), .DEPTH(D)) bif4 ();
    fourstate_bus_sampler #(.WIDTH(4), .DEPTH(D)) dut4 (.clk(clk), .rst(rst), .bus(bif4));

    typedef struct {
        logic [2*W-1:0] code;
        int             xc;
        int             zc;
        bit             az;
    } mrec_t;

    mrec_t mq[$];
    bit    m_ovf;
    int    m_drops;
    int    checks   = 0;
    int    failures = 0;

    // Classify the low n bits of v into symbols and tallies.
    function automatic mrec_t model_encode(input logic [W-1:0] v, input int n);
        mrec_t r;
        logic  b;
        r.code = '0;
        r.xc   = 0;
        r.zc   = 0;
        for (int i = 0; i < n; i++) begin
            b = v[i];
            if (b === 1'b0) begin
            end else if (b === 1'b1) begin
                r.code[2*i] = 1'b1;
            end else if (b === 1'bz) begin
                r.code[2*i+1] = 1'b1;
                r.zc++;
            end else begin
                r.code[2*i+1] = 1'b1;
                r.code[2*i]   = 1'b1;
                r.xc++;
            end
        end
        r.az = (r.zc == n);
        return r;
    endfunction

    function automatic mrec_t head_exp();
        mrec_t r;
        r.code = '0; r.xc = 0; r.zc = 0; r.az = 1'b0;
        if (mq.size() > 0) r = mq[0];
        return r;
    endfunction

    // Drive one cycle on the 24-bit instance and advance the reference queue.
    task automatic cycle(input bit s, input bit r, input logic [W-1:0] v, input bit rs);
        bit do_pop;
        rst = rs; bif.sample_i = s; bif.out_ready = r; bif.bus_in = v;
        if (rs) begin
            mq.delete(); m_ovf = 1'b0; m_drops = 0;
        end else begin
            do_pop = (mq.size() > 0) && r;
            if (do_pop) void'(mq.pop_front());
            if (s) begin
                if (mq.size() < D) mq.push_back(model_encode(bif.bus_in, W));
                else begin
                    m_ovf = 1'b1;
                    if (m_drops < 255) m_drops++;
                end
            end
        end
        @(posedge clk); #1;
    endtask

    function automatic logic [W-1:0] rand_bus();
        logic [W-1:0] v;
        int k;
        for (int i = 0; i < W; i++) begin
            k = $urandom_range(0, 9);
            if (k < 7)       v[i] = 1'($urandom_range(0, 1));
            else if (k == 7) v[i] = 1'b1;
            else if (k == 8) v[i] = 1'bz;
            else             v[i] = 1'bx;
        end
        return v;
    endfunction

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            cycle(1'b1, 1'b0, '1, 1'b1);
            checks++; if (bif.fifo_count !== '0) begin failures++; $display("FAIL reset_count cyc%0d: got %0d want 0", c, bif.fifo_count); end
            checks++; if (bif.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid cyc%0d: got %b want 0", c, bif.out_valid); end
            checks++; if (bif.overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf cyc%0d: got %b want 0", c, bif.overflow); end
        end
        cycle(1'b0, 1'b0, '0, 1'b0);
        checks++; if (bif.out_valid !== 1'b0) begin failures++; $display("FAIL post_reset_valid: got %b want 0", bif.out_valid); end
        checks++;
        if (bif.out_code !== '0 || bif.out_x_cnt !== '0 || bif.out_z_cnt !== '0 || bif.out_all_z !== 1'b0 || bif.drop_cnt !== '0) begin
            failures++;
            $display("FAIL reset_head: code=%h x=%0d z=%0d allz=%b drop=%0d want all 0", bif.out_code, bif.out_x_cnt, bif.out_z_cnt, bif.out_all_z, bif.drop_cnt);
        end
    endtask

    task automatic test_encode4();
        mrec_t e;
        bif4.bus_in = 4'b1x0z; bif4.sample_i = 1'b1; bif4.out_ready = 1'b1;
        e = model_encode(W'(bif4.bus_in), 4);
        cycle(1'b0, 1'b0, '0, 1'b0);
        bif4.sample_i = 1'b0;
        checks++; if (bif4.out_valid !== 1'b1) begin failures++; $display("FAIL enc4_valid: got %b want 1", bif4.out_valid); end
        checks++;
        if (bif4.out_code !== e.code[7:0] || bif4.out_x_cnt !== 3'(e.xc) || bif4.out_z_cnt !== 3'(e.zc) || bif4.out_all_z !== e.az) begin
            failures++;
            $display("FAIL enc4_head: code=%b x=%0d z=%0d allz=%b want code=%b x=%0d z=%0d allz=%b",
                     bif4.out_code, bif4.out_x_cnt, bif4.out_z_cnt, bif4.out_all_z, e.code[7:0], e.xc, e.zc, e.az);
        end
        cycle(1'b0, 1'b0, '0, 1'b0);
        checks++; if (bif4.fifo_count !== '0 || bif4.out_valid !== 1'b0) begin failures++; $display("FAIL enc4_popped: count=%0d valid=%b want 0 0", bif4.fifo_count, bif4.out_valid); end
        bif4.out_ready = 1'b0;
    endtask

    task automatic test_all_zx();
        mrec_t e;
        cycle(1'b1, 1'b0, {W{1'bz}}, 1'b0);
        e = head_exp();
        checks++;
        if (bif.out_valid !== 1'b1 || bif.out_code !== e.code || bif.out_z_cnt !== CW'(e.zc) || bif.out_x_cnt !== CW'(e.xc) || bif.out_all_z !== e.az) begin
            failures++;
            $display("FAIL all_z: valid=%b code=%h x=%0d z=%0d allz=%b want code=%h x=%0d z=%0d allz=%b",
                     bif.out_valid, bif.out_code, bif.out_x_cnt, bif.out_z_cnt, bif.out_all_z, e.code, e.xc, e.zc, e.az);
        end
        cycle(1'b1, 1'b1, {W{1'bx}}, 1'b0);
        e = head_exp();
        checks++;
        if (bif.out_valid !== 1'b1 || bif.out_code !== e.code || bif.out_x_cnt !== CW'(e.xc) || bif.out_z_cnt !== CW'(e.zc) || bif.out_all_z !== e.az) begin
            failures++;
            $display("FAIL all_x: valid=%b code=%h x=%0d z=%0d allz=%b want code=%h x=%0d z=%0d allz=%b",
                     bif.out_valid, bif.out_code, bif.out_x_cnt, bif.out_z_cnt, bif.out_all_z, e.code, e.xc, e.zc, e.az);
        end
        cycle(1'b0, 1'b1, '0, 1'b0);
        checks++; if (bif.out_valid !== 1'b0 || bif.fifo_count !== '0) begin failures++; $display("FAIL zx_drain: valid=%b count=%0d want 0 0", bif.out_valid, bif.fifo_count); end
    endtask

    task automatic test_overflow();
        mrec_t e;
        for (int k = 0; k < 6; k++) cycle(1'b1, 1'b0, W'(k), 1'b0);
        checks++;
        if (bif.fifo_count !== AW'(4) || bif.overflow !== 1'b1 || bif.drop_cnt !== 8'd2) begin
            failures++;
            $display("FAIL ovf_state: count=%0d ovf=%b drop=%0d want 4 1 2", bif.fifo_count, bif.overflow, bif.drop_cnt);
        end
        for (int k = 0; k < 4; k++) begin
            e = model_encode(W'(k), W);
            checks++;
            if (bif.out_valid !== 1'b1 || bif.out_code !== e.code) begin
                failures++;
                $display("FAIL ovf_order%0d: valid=%b code=%h want 1 %h", k, bif.out_valid, bif.out_code, e.code);
            end
            cycle(1'b0, 1'b1, '0, 1'b0);
        end
        checks++; if (bif.out_valid !== 1'b0) begin failures++; $display("FAIL ovf_empty: valid=%b want 0", bif.out_valid); end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] v;
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, W'($urandom), 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1);
        checks++;
        if (bif.fifo_count !== '0 || bif.out_valid !== 1'b0 || bif.drop_cnt !== '0 || bif.overflow !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: count=%0d valid=%b drop=%0d ovf=%b want 0 0 0 0", bif.fifo_count, bif.out_valid, bif.drop_cnt, bif.overflow);
        end
        v = W'($urandom);
        cycle(1'b1, 1'b0, v, 1'b0);
        checks++;
        if (bif.out_valid !== 1'b1 || bif.out_code !== model_encode(v, W).code) begin
            failures++;
            $display("FAIL mid_fresh: valid=%b code=%h want 1 %h", bif.out_valid, bif.out_code, model_encode(v, W).code);
        end
        cycle(1'b0, 1'b1, '0, 1'b0);
    endtask

    task automatic test_full_push_pop();
        logic [W-1:0] v;
        mrec_t e;
        cycle(1'b0, 1'b0, '0, 1'b1);
        for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, W'($urandom), 1'b0);
        v = W'($urandom);
        cycle(1'b1, 1'b1, v, 1'b0);
        checks++;
        if (bif.fifo_count !== AW'(4) || bif.overflow !== 1'b0 || bif.drop_cnt !== '0) begin
            failures++;
            $display("FAIL full_pp: count=%0d ovf=%b drop=%0d want 4 0 0", bif.fifo_count, bif.overflow, bif.drop_cnt);
        end
        for (int k = 0; k < 4; k++) begin
            e = head_exp();
            checks++;
            if (bif.out_valid !== 1'b1 || bif.out_code !== e.code) begin
                failures++;
                $display("FAIL full_pp_order%0d: valid=%b code=%h want 1 %h", k, bif.out_valid, bif.out_code, e.code);
            end
            if (k == 3) begin
                checks++;
                if (bif.out_code !== model_encode(v, W).code) begin failures++; $display("FAIL full_pp_last: code=%h want %h", bif.out_code, model_encode(v, W).code); end
            end
            cycle(1'b0, 1'b1, '0, 1'b0);
        end
    endtask

    task automatic test_saturate();
        cycle(1'b0, 1'b0, '0, 1'b1);
        for (int k = 0; k < 262; k++) cycle(1'b1, 1'b0, W'(k), 1'b0);
        checks++;
        if (bif.drop_cnt !== 8'(m_drops) || bif.drop_cnt !== 8'd255) begin
            failures++;
            $display("FAIL drop_sat: got %0d want 255", bif.drop_cnt);
        end
    endtask

    task automatic test_random();
        mrec_t e;
        bit rs;
        for (int c = 0; c < 600; c++) begin
            rs = ($urandom_range(0, 59) == 0);
            cycle(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), rand_bus(), rs);
            e = head_exp();
            checks++; if (bif.fifo_count !== AW'(mq.size())) begin failures++; $display("FAIL rnd_count c%0d: got %0d want %0d", c, bif.fifo_count, mq.size()); end
            checks++; if (bif.out_valid !== (mq.size() > 0)) begin failures++; $display("FAIL rnd_valid c%0d: got %b want %b", c, bif.out_valid, mq.size() > 0); end
            checks++; if (bif.overflow !== m_ovf || bif.drop_cnt !== 8'(m_drops)) begin failures++; $display("FAIL rnd_ovf c%0d: ovf=%b drop=%0d want %b %0d", c, bif.overflow, bif.drop_cnt, m_ovf, m_drops); end
            if (mq.size() > 0) begin
                checks++;
                if (bif.out_code !== e.code || bif.out_x_cnt !== CW'(e.xc) || bif.out_z_cnt !== CW'(e.zc) || bif.out_all_z !== e.az) begin
                    failures++;
                    $display("FAIL rnd_head c%0d: code=%h x=%0d z=%0d allz=%b want code=%h x=%0d z=%0d allz=%b",
                             c, bif.out_code, bif.out_x_cnt, bif.out_z_cnt, bif.out_all_z, e.code, e.xc, e.zc, e.az);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bif.sample_i = 1'b0; bif.out_ready = 1'b0; bif.bus_in = '0;
        bif4.sample_i = 1'b0; bif4.out_ready = 1'b0; bif4.bus_in = '0;
        test_reset();
        test_encode4();
        test_all_zx();
        test_overflow();
        test_reset_mid();
        test_full_push_pop();
        test_saturate();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fourstate_bus_sampler.md
Name: fourstate_bus_sampler

Overview:
Sampling monitor for multi-driven 4-state nets, such as wor/wand/tri0/tri1 buses driven with literals containing x and z.
- On a strobe it captures a packed logic bus and encodes every bit as a 2-bit symbol.
- It counts x and z bits, then queues the record in a small FIFO drained over a valid/ready handshake.
- It is the read-back end for net-driving stimulus modules and is used in benches to check net resolution; it is a simulation-side block.

Parameters:
WIDTH, 24, bit width of sampled bus (1..64)
DEPTH, 4, FIFO entries (power of two, 2..16)
CW, $clog2(WIDTH+1), width of x/z count fields
AW, $clog2(DEPTH+1), width of occupancy count

Ports:
clk  input  1  sole clock, all state on posedge
rst  input  1  synchronous active-high reset
bus_in  input  WIDTH  monitored 4-state logic bus (bit WIDTH-1 = MSB)
sample_i  input  1  capture strobe, one sample per cycle high
out_valid  output  1  FIFO head record available
out_ready  input  1  consumer accepts head when out_valid & out_ready
out_code  output  2*WIDTH  encoded head; bits [2i+1:2i] encode bus bit i
out_x_cnt  output  CW  number of x bits in head record
out_z_cnt  output  CW  number of z bits in head record
out_all_z  output  1  head record was entirely z (undriven bus)
fifo_count  output  AW  current occupancy, 0..DEPTH
overflow  output  1  sticky, set when a sample is dropped while full
drop_cnt  output  8  saturating count of dropped samples

Behaviour:
- Reset: the synchronous rst (active-high, sampled on posedge clk) has priority over everything else.
  - Empties the FIFO (rd/wr pointers 0) and sets fifo_count=0.
  - out_valid=0, overflow=0, drop_cnt=0; out_code, out_x_cnt, out_z_cnt and out_all_z all 0.
  - A sample or pop in the reset cycle is ignored.
- Encoding uses case-equality per bit: 0->2'b00, 1->2'b01, z->2'b10, x->2'b11. The output never carries x/z, even when bus_in is fully x/z.
- Counts:
  - x_cnt = number of 2'b11 symbols; z_cnt = number of 2'b10 symbols.
  - all_z = (z_cnt==WIDTH).
  - Computed from the same capture as the code.
- Capture: when sample_i=1 at posedge, bus_in is encoded and written to the FIFO in that cycle. With the FIFO previously empty, out_valid rises the following cycle (1-cycle latency).
- Head outputs are registered from FIFO storage at rd pointer. They are stable while out_valid=1 and out_ready=0; out_code, the counts and all_z hold their values until accepted.
- Pop: out_valid & out_ready at posedge advances the rd pointer. The next entry (if any) appears on the following cycle with no bubble.
- Simultaneous push and pop:
  - When full, the push is accepted because the pop frees a slot; fifo_count is unchanged and overflow is not set.
  - When empty, only the push applies.
- Full (fifo_count==DEPTH) with push and no pop: the sample is dropped, overflow is set (sticky until rst), and drop_cnt increments, saturating at 255.
- Pointers wrap modulo DEPTH; full/empty are derived from fifo_count.
- out_ready while out_valid=0 has no effect.
- Reset mid-operation discards all queued records; out_valid is 0 on the cycle after rst.

Test Plan:
1. rst=1 for 2 cycles with sample_i=1 and bus_in=24'hFFFFFF. Required: fifo_count=0, out_valid=0, overflow=0 throughout; out_valid stays 0 for 1 cycle after rst drops with sample_i=0.
2. WIDTH=4, bus_in=4'b1x0z, one sample, out_ready=1. Required: out_valid=1 one cycle later; out_code=8'b01_11_00_10, x_cnt=1, z_cnt=1, all_z=0; fifo_count back to 0 after the pop.
3. bus_in all z (24'bz), sample. Required: out_code=48'hAAAA_AAAA_AAAA, z_cnt=24, x_cnt=0, all_z=1. Then bus_in all x: out_code=48'hFFFF_FFFF_FFFF, x_cnt=24.
4. out_ready=0 and 6 consecutive samples with values 0..5. Required: fifo_count=4, overflow=1, drop_cnt=2. Then out_ready=1: records for values 0,1,2,3 emerge in order on 4 consecutive cycles, then out_valid=0.
5. FIFO full, sample_i=1 and out_ready=1 in the same cycle. Required: fifo_count stays 4, overflow stays 0, new record appears last in order.
6. Three records queued, out_ready=0, rst pulsed for one cycle. Required: next cycle fifo_count=0, out_valid=0, drop_cnt=0; a fresh sample afterwards is output with 1-cycle latency.
